instr_fetch_unit: RTL and testbench

//  Fetch stage feeding instruction decode and the immediate generator. Holds the PC and issues

---
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, 1-cycle instruction memory requests, 2-entry {pc, instruction} buffer to decode.
// Optional feature macro MISALIGN_TRAP_EN: misaligned redirect targets trap and halt fetch.
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h13
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instruction,
    input  logic            id_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            if_misaligned
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [XLEN-1:0] pc_q;
    logic [1:0]      count;
    logic            inflight_q;
    logic            head_q;
    logic            tail_q;

    logic [XLEN-1:0] req_pc_p1;
    logic [XLEN-1:0] fifo_pc    [2];
    logic [31:0]     fifo_instr [2];

    logic            redirect_run;
    logic            trap;
    logic            flush;
    logic            pop;
    logic            push;
    logic [2:0]      occupancy;
    logic [XLEN-1:0] target_aligned;

    assign redirect_run   = (state_q == RUN) && redirect_valid;
    assign flush          = redirect_run;
    assign target_aligned = redirect_target & ~{{(XLEN-2){1'b0}}, 2'b11};

`ifdef MISALIGN_TRAP_EN
    logic misaligned_q;

    assign trap          = redirect_run && (redirect_target[1:0] != 2'b00);
    assign if_misaligned = misaligned_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (trap) begin
            misaligned_q <= 1'b1;
        end
    end
`else
    assign trap          = 1'b0;
    assign if_misaligned = 1'b0;
`endif

    // A redirect voids the pop and drops the response currently returning.
    assign pop       = if_valid && id_ready && !flush;
    assign push      = inflight_q && !flush;
    assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, if_valid && id_ready};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (trap) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if (state_q == RUN) begin
            imem_req = !redirect_valid && (occupancy < 3'd2);
        end
    end

    // Control: pc, in-flight flag, buffer pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            count      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (flush) begin
                count  <= 2'd0;
                head_q <= 1'b0;
                tail_q <= 1'b0;
                pc_q   <= target_aligned;
            end else begin
                if (imem_req) begin
                    pc_q <= pc_q + XLEN'(4);
                end
                if (push) begin
                    tail_q <= ~tail_q;
                end
                if (pop) begin
                    head_q <= ~head_q;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Stage p1: pc of the outstanding request, written into the buffer with its data.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            req_pc_p1 <= pc_q;
        end
        if (push) begin
            fifo_pc[tail_q]    <= req_pc_p1;
            fifo_instr[tail_q] <= imem_rdata[31:0];
        end
    end

    assign imem_addr      = pc_q;
    assign if_valid       = (count != 2'd0);
    assign if_pc          = if_valid ? fifo_pc[head_q] : '0;
    assign if_instruction = if_valid ? fifo_instr[head_q] : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a pc scoreboard checked on every decode handshake.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] MAGIC  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_misaligned;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .NOP_INSTR(32'h13)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_misaligned  (if_misaligned)
    );

    always #5 clk = ~clk;

    // Memory model: data returns the cycle after a request, garbage otherwise.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ MAGIC;
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        logic [31:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, if_valid, 1'b0);
        check({tag, "_pc"}, if_pc, 32'h0);
        check({tag, "_instr"}, if_instruction, 32'h13);
        check({tag, "_req"}, imem_req, 1'b0);
        check({tag, "_addr"}, imem_addr, RST_PC);
        check({tag, "_misaligned"}, if_misaligned, 1'b0);
    endtask

    // Scoreboard: every accepted head must be the next expected pc/instruction.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            tests++;
            assert (dut.count <= 2'd2) else begin
                fails++;
                $error("FAIL count_bound: observed %0d expected <=2", dut.count);
            end
            if (!redirect_valid && if_valid && id_ready) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL sb_unexpected: observed pc %0h expected no delivery", if_pc);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_pc", if_pc, e);
                    check("sb_instr", if_instruction, e ^ MAGIC);
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        id_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (2) tick();
        check_reset_values("reset");

        // 1) boot latency and back-to-back delivery
        fill(RST_PC, 64);
        reset = 1'b0;
        tick();
        check("t1_valid_e1", if_valid, 1'b0);
        check("t1_req_e1", imem_req, 1'b1);
        tick();
        check("t1_valid_e2", if_valid, 1'b0);
        tick();
        check("t1_valid_e3", if_valid, 1'b1);
        check("t1_pc_e3", if_pc, 32'h100);
        tick();
        check("t1_pc_e4", if_pc, 32'h104);
        tick();
        check("t1_pc_e5", if_pc, 32'h108);

        // 2) decode stall fills the buffer and stops requests
        id_ready = 1'b0;
        repeat (6) tick();
        check("t2_req", imem_req, 1'b0);
        check("t2_count", dut.count, 2'd2);
        check("t2_head", if_pc, 32'h108);
        id_ready = 1'b1;
        repeat (8) tick();

        // 3) redirect with a fetch in flight
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        exp_q.delete();
        fill(32'h200, 32);
        #1;
        check("t3_req_redirect", imem_req, 1'b0);
        tick();
        redirect_valid = 1'b0;
        check("t3_valid_r1", if_valid, 1'b0);
        tick();
        check("t3_valid_r2", if_valid, 1'b0);
        tick();
        check("t3_pc_r3", if_pc, 32'h200);
        repeat (4) tick();

        // 4) redirect to the top of the address space wraps to 0
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        exp_q.delete();
        fill(32'hFFFF_FFFC, 32);
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        check("t4_pc_top", if_pc, 32'hFFFF_FFFC);
        tick();
        check("t4_pc_wrap", if_pc, 32'h0);
        repeat (3) tick();

        // 5) asynchronous reset mid-operation
        check("t5_pre_inflight", dut.inflight_q, 1'b1);
        check("t5_pre_count", dut.count, 2'd1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_values("t5_async");
        tick();
        reset = 1'b0;
        fill(RST_PC, 32);
        repeat (3) tick();
        check("t5_first_pc", if_pc, RST_PC);
        repeat (3) tick();

        // 6) misaligned redirect target
        redirect_valid  = 1'b1;
        redirect_target = 32'h202;
        exp_q.delete();
`ifdef MISALIGN_TRAP_EN
        tick();
        redirect_valid = 1'b0;
        check("t6_misaligned", if_misaligned, 1'b1);
        check("t6_flushed", if_valid, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t6_req_halt", imem_req, 1'b0);
            check("t6_sticky", if_misaligned, 1'b1);
        end
`else
        fill(32'h200, 32);
        tick();
        redirect_valid = 1'b0;
        check("t6_misaligned_tied", if_misaligned, 1'b0);
        repeat (2) tick();
        check("t6_pc_aligned", if_pc, 32'h200);
        repeat (3) tick();
`endif

        id_ready = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
